// File: rtl/game_ctrl_pkg.sv
// game_ctrl_pkg: shared state encoding and default object indices for the frog game controller
package game_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, PLAY, DIVE, HIT, WIN, GAME_OVER, PAUSED} game_state_t;
    localparam int WATERFALL = 0;
    localparam int FROG      = 1;
    localparam int LOG       = 2;
    localparam int FRENCH    = 3;
    localparam int ENDBANK   = 5;
    localparam int TANK      = 7;
endpackage

// File: rtl/game_frame_timer.sv
// game_frame_timer: loadable down-counter stepped once per frame
// Ports: clk, reset (sync active-high), sof (frame strobe), en (0 freezes count),
//        load/load_val (load wins over decrement), count (stops at 0)
module game_frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sof,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);
    always_ff @(posedge clk)
        if (reset) count <= '0;
        else if (load) count <= load_val;
        else if (sof && en && count != '0) count <= count - 1'b1;
endmodule

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: frog game controller - draw mux priority encoder, frog hit capture, per-frame game FSM and lives
// Ports: clk, reset (sync active-high), draw_req[NUM_OBJ], sof, start, pause (GAME_CTRL_PAUSE_EN only),
//        select_mux[SEL_W], draw_valid, play, dive, win, lose, game_over, lives_left[4]
// Config: defining GAME_CTRL_PAUSE_EN adds the pause input and the PAUSED state
module game_ctrl_fsm
    import game_ctrl_pkg::*;
#(
    parameter int                 NUM_OBJ     = 8,
    parameter int                 SEL_W       = $clog2(NUM_OBJ),
    parameter int                 FROG_IDX    = FROG,
    parameter logic [NUM_OBJ-1:0] WIN_MASK    = NUM_OBJ'(8'b0010_0000),
    parameter logic [NUM_OBJ-1:0] LOSE_MASK   = NUM_OBJ'(8'b0000_1101),
    parameter logic [NUM_OBJ-1:0] DIVE_MASK   = NUM_OBJ'(8'b1000_0000),
    parameter logic [NUM_OBJ-1:0] IMMUNE_MASK = NUM_OBJ'(8'b0000_0100),
    parameter int                 LIVES       = 3,
    parameter int                 DIVE_FRAMES = 120,
    parameter int                 HOLD_FRAMES = 90
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_OBJ-1:0] draw_req,
    input  logic               sof,
    input  logic               start,
`ifdef GAME_CTRL_PAUSE_EN
    input  logic               pause,
`endif
    output logic [SEL_W-1:0]   select_mux,
    output logic               draw_valid,
    output logic               play,
    output logic               dive,
    output logic               win,
    output logic               lose,
    output logic               game_over,
    output logic [3:0]         lives_left
);
    localparam logic [NUM_OBJ-1:0] NOT_FROG  = ~(NUM_OBJ'(1) << FROG_IDX);
    localparam logic [NUM_OBJ-1:0] W_MASK    = WIN_MASK & NOT_FROG;
    localparam logic [NUM_OBJ-1:0] L_MASK    = LOSE_MASK & NOT_FROG;
    localparam logic [NUM_OBJ-1:0] L_MASK_DV = L_MASK & ~IMMUNE_MASK;
    localparam logic [NUM_OBJ-1:0] D_MASK    = DIVE_MASK & NOT_FROG;
    localparam int TW = $clog2((DIVE_FRAMES > HOLD_FRAMES ? DIVE_FRAMES : HOLD_FRAMES) + 1);

    game_state_t state, state_n, saved_state;
    logic hit_win, hit_lose, hit_dive, start_lat, start_any;
    logic frog_on, cap_win, cap_lose, cap_dive, res_win, res_lose, res_dive;
    logic pause_rise, dive_load, hold_load;
    logic [TW-1:0] dive_cnt, hold_cnt;

    always_comb begin
        select_mux = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--)
            if (draw_req[i]) select_mux = SEL_W'(i);
    end
    assign draw_valid = |draw_req;

    // Only PLAY/DIVE capture; hits anywhere else are simply never recorded.
    assign frog_on  = (state == PLAY || state == DIVE) && draw_req[FROG_IDX];
    assign cap_win  = frog_on && |(draw_req & W_MASK);
    assign cap_lose = frog_on && |(draw_req & (state == DIVE ? L_MASK_DV : L_MASK));
    assign cap_dive = frog_on && |(draw_req & D_MASK);
    // Resolution on sof must also see a hit landing on the sof cycle itself.
    assign res_win  = hit_win  || cap_win;
    assign res_lose = hit_lose || cap_lose;
    assign res_dive = hit_dive || cap_dive;
    assign start_any = start_lat || start;

`ifdef GAME_CTRL_PAUSE_EN
    logic pause_d;
    always_ff @(posedge clk)
        pause_d <= reset ? 1'b0 : pause;
    assign pause_rise = pause && !pause_d;
`else
    assign pause_rise = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        dive_load = 1'b0;
        case (state)
            IDLE:      state_n = sof && start_any ? PLAY : IDLE;
            PLAY, DIVE: begin
                if (pause_rise) state_n = PAUSED;
                else if (sof) begin
                    if (res_win) state_n = WIN;
                    else if (res_lose) state_n = HIT;
                    else if (res_dive) begin
                        state_n   = DIVE;
                        dive_load = 1'b1;
                    end
                    else if (state == DIVE && dive_cnt <= TW'(1)) state_n = PLAY;
                end
            end
            HIT:       if (sof && hold_cnt <= TW'(1)) state_n = lives_left != 4'd0 ? PLAY : GAME_OVER;
            WIN:       if (sof && hold_cnt <= TW'(1)) state_n = IDLE;
            GAME_OVER: if (sof && start_any) state_n = IDLE;
            PAUSED:    if (pause_rise) state_n = saved_state;
            default:   state_n = IDLE;
        endcase
    end

    assign hold_load = (state_n == HIT || state_n == WIN) && state_n != state;

    game_frame_timer #(.W(TW)) u_dive_timer (
        .clk(clk), .reset(reset), .sof(sof), .en(state != PAUSED),
        .load(dive_load), .load_val(TW'(DIVE_FRAMES)), .count(dive_cnt)
    );

    game_frame_timer #(.W(TW)) u_hold_timer (
        .clk(clk), .reset(reset), .sof(sof), .en(state != PAUSED),
        .load(hold_load), .load_val(TW'(HOLD_FRAMES)), .count(hold_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            saved_state <= IDLE;
            hit_win     <= 1'b0;
            hit_lose    <= 1'b0;
            hit_dive    <= 1'b0;
            start_lat   <= 1'b0;
            lives_left  <= 4'(LIVES);
            play        <= 1'b0;
            dive        <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state     <= state_n;
            hit_win   <= !sof && res_win;
            hit_lose  <= !sof && res_lose;
            hit_dive  <= !sof && res_dive;
            start_lat <= !sof && start_any;
            if (state_n == PAUSED && state != PAUSED) saved_state <= state;
            if (state == GAME_OVER && state_n == IDLE) lives_left <= 4'(LIVES);
            else if (state_n == HIT && state != HIT && lives_left != 4'd0) lives_left <= lives_left - 4'd1;
            // Flags trail the state by one clk and are frozen while paused.
            if (state != PAUSED) begin
                play      <= state == PLAY || state == DIVE;
                dive      <= state == DIVE;
                win       <= state == WIN;
                lose      <= state == HIT || state == GAME_OVER;
                game_over <= state == GAME_OVER;
            end
        end
    end
endmodule
